// File: rtl/gcd_unit_4b_ctrl.sv
// Iterative 4-bit GCD (Euclid by repeated subtraction) with val/rdy streams.
// A three-state FSM sequences one shared 4-bit subtractor.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   istream_val/rdy   operand handshake, in_a/in_b 4-bit unsigned operands
//   ostream_val/rdy   result handshake, result 4-bit gcd(A,B)
//   busy              high while computing or holding a result

module gcd_sub4 (
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);
    // The fifth bit of the widened difference is the borrow out.
    assign {bout, diff} = {1'b0, in0} - {1'b0, in1} - {4'b0, bin};
endmodule

module gcd_unit_4b_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       istream_val,
    output logic       istream_rdy,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       ostream_val,
    input  logic       ostream_rdy,
    output logic [3:0] result,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;

    logic [3:0] sub_diff;
    logic       sub_bout;

    gcd_sub4 u_sub (
        .in0  (a_q),
        .in1  (b_q),
        .bin  (1'b0),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (istream_val) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Borrow out means A<B: swap so the next step can subtract.
                if (b_q == 4'd0) begin
                    state_d = DONE;
                end else if (sub_bout) begin
                    a_d = b_q;
                    b_d = a_q;
                end else begin
                    a_d = sub_diff;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on state and reset, never on the stream inputs.
    always_comb begin
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        busy        = 1'b0;
        result      = 4'd0;
        if (!rst) begin
            result = a_q;
            case (state_q)
                IDLE:    istream_rdy = 1'b1;
                CALC:    busy = 1'b1;
                DONE: begin
                    busy        = 1'b1;
                    ostream_val = 1'b1;
                end
                default: istream_rdy = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_unit_4b_ctrl.sv
// Directed bench for gcd_unit_4b_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_gcd_unit_4b_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       istream_val;
    logic       istream_rdy;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       ostream_val;
    logic       ostream_rdy;
    logic [3:0] result;
    logic       busy;

    int total = 0;
    int bad   = 0;

    gcd_unit_4b_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .in_a        (in_a),
        .in_b        (in_b),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .result      (result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge of cycle 1.
    task automatic start_op(input string tag, input logic [3:0] a,
                            input logic [3:0] b);
        chk({tag, "_in_rdy"}, istream_rdy, 1);
        in_a        = a;
        in_b        = b;
        istream_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_rdy_c1"}, istream_rdy, 0);
    endtask

    // Starts at cycle 1; returns at the falling edge of the first DONE cycle.
    task automatic wait_out(input string tag, input int exp_res,
                            input int exp_cyc);
        int c = 1;
        while (!ostream_val && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_cycle"}, c[7:0], exp_cyc[7:0]);
        chk({tag, "_result"}, result, exp_res[7:0]);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_rdy_done"}, istream_rdy, 0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] a,
                          input logic [3:0] b, input int exp_res,
                          input int exp_cyc);
        ostream_rdy = 1'b1;
        start_op(tag, a, b);
        istream_val = 1'b0;
        wait_out(tag, exp_res, exp_cyc);
        @(negedge clk);
        chk({tag, "_idle_rdy"}, istream_rdy, 1);
        chk({tag, "_idle_val"}, ostream_val, 0);
    endtask

    initial begin
        int seen;
        rst         = 1'b1;
        istream_val = 1'b1;
        in_a        = 4'd5;
        in_b        = 4'd3;
        ostream_rdy = 1'b1;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_in_rdy", istream_rdy, 0);
            chk("rst_out_val", ostream_val, 0);
            chk("rst_result", result, 0);
            chk("rst_busy", busy, 0);
        end
        rst         = 1'b0;
        istream_val = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", istream_rdy, 1);
        chk("post_rst_val", ostream_val, 0);
        chk("post_rst_result", result, 0);

        run_op("g12_8", 4'd12, 4'd8, 4, 7);
        run_op("g0_0", 4'd0, 4'd0, 0, 2);
        run_op("g0_9", 4'd0, 4'd9, 9, 3);
        run_op("g7_0", 4'd7, 4'd0, 7, 2);
        run_op("g15_1", 4'd15, 4'd1, 1, 18);
        run_op("g13_5", 4'd13, 4'd5, 1, 12);
        run_op("g9_6", 4'd9, 4'd6, 3, 7);

        // Backpressure with new operands waiting on the input side.
        ostream_rdy = 1'b0;
        start_op("bp", 4'd6, 4'd4);
        in_a = 4'd10;
        in_b = 4'd5;
        wait_out("bp", 2, 7);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_val", ostream_val, 1);
            chk("bp_hold_result", result, 2);
            chk("bp_hold_in_rdy", istream_rdy, 0);
            @(negedge clk);
        end
        chk("bp_still_val", ostream_val, 1);
        ostream_rdy = 1'b1;
        @(negedge clk);
        chk("bp_idle_rdy", istream_rdy, 1);
        chk("bp_idle_val", ostream_val, 0);
        @(negedge clk);
        istream_val = 1'b0;
        chk("bp_new_busy", busy, 1);
        wait_out("bp_new", 5, 5);
        @(negedge clk);
        chk("bp_new_idle", istream_rdy, 1);

        // Reset in cycle 5 of the worst-case operation.
        start_op("mid", 4'd15, 4'd1);
        istream_val = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("mid_c5_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_val", ostream_val, 0);
        chk("mid_rst_result", result, 0);
        rst = 1'b0;
        #1;
        chk("mid_idle_rdy", istream_rdy, 1);
        chk("mid_idle_busy", busy, 0);
        chk("mid_idle_result", result, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ostream_val) seen++;
        end
        chk("mid_no_output", seen[7:0], 0);
        run_op("g10_4", 4'd10, 4'd4, 2, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gcd_unit_4b_ctrl.md
Name: gcd_unit_4b_ctrl

Overview:
- Iterative 4-bit GCD unit using Euclid's algorithm by repeated subtraction.
- A small FSM sequences one shared 4-bit subtractor datapath, with ports in0, in1, bin, bout and diff:
  - each cycle it either subtracts, swaps operands, or finishes;
  - it uses bout as the less-than flag.
- Val/rdy streaming handshake on both the input and output sides.
- Sits after the absdiff datapath as the first multi-cycle consumer of the subtractor in the lab design.

Parameters:
- None. Width is fixed at 4 bits to match the shared subtractor.

Ports:
- clk          input   1  clock; all state updates on the rising edge
- rst          input   1  synchronous, active-high reset
- istream_val  input   1  in_a/in_b are valid
- istream_rdy  output  1  block can accept operands
- in_a         input   4  operand A, unsigned
- in_b         input   4  operand B, unsigned
- ostream_val  output  1  result is valid
- ostream_rdy  input   1  consumer accepts result
- result       output  4  gcd(A,B), unsigned
- busy         output  1  high in the CALC or DONE state

Behaviour:
- One clock; reset is synchronous and active-high.
- Internal registers:
  - state: {IDLE, CALC, DONE}
  - A[3:0], B[3:0]
- Shared subtractor hookup: in0=A, in1=B, bin=0. A<B iff bout=1. Use diff for A-B.
- Reset (rst high at an edge):
  - state<=IDLE, A<=0, B<=0.
  - While rst is high, istream_rdy=0, ostream_val=0, busy=0, result=0.
  - Reset overrides everything, including mid-CALC and mid-DONE.
  - An in-flight computation is discarded and no result is produced.
- IDLE:
  - istream_rdy=1, ostream_val=0, busy=0.
  - On istream_val && istream_rdy: A<=in_a, B<=in_b, go to CALC.
  - Otherwise hold.
- CALC (istream_rdy=0, ostream_val=0, busy=1). Priority per cycle:
  1. B==0: go to DONE, registers unchanged.
  2. Else if bout==1 (A<B): A<=B, B<=A (swap), stay in CALC.
  3. Else: A<=diff (A-B, no wrap since A>=B), stay in CALC.
- DONE:
  - ostream_val=1, result=A, busy=1, istream_rdy=0.
  - On ostream_rdy: go to IDLE.
  - Otherwise hold; result stays stable while ostream_val is high and ostream_rdy is low.
- No overlap: a new input is accepted no earlier than the cycle after the output handshake.
- Outputs are decoded from state; there is no combinational path from istream_val or ostream_rdy to any output.
- result equals A in every state (0 after reset). It is only meaningful when ostream_val=1.
- Latency, with the handshake in cycle 0:
  - CALC occupies cycles 1..N, where N = subtract steps + swap steps + 1 (the B==0 check).
  - ostream_val first asserts in cycle N+1.
- Boundary cases:
  - A=B=0: N=1, result 0.
  - A=0, B=k: swap, then done. N=2, result k.
  - A=k, B=0: N=1, result k.
  - Worst case is (15,1): 15 subtracts, a swap (0,1)->(1,0), then done, so N=17.
  - Arithmetic never underflows because a subtract only occurs when bout=0.
- istream_val while busy is ignored; no input is latched.

Test Plan:
- Reset:
  - Stimulus: hold rst for 2 cycles with istream_val=1.
  - Required response:
    - during rst: istream_rdy=0, ostream_val=0, result=0;
    - first cycle after rst: istream_rdy=1.
- Basic GCD:
  - Stimulus: in_a=12, in_b=8, handshake in cycle 0, ostream_rdy=1.
  - Required response:
    - the sequence (12,8)->(4,8)->(8,4)->(4,4)->(0,4)->(4,0) gives N=6;
    - ostream_val=1 with result=4 in cycle 7;
    - istream_rdy=1 in cycle 8.
- Zero operands:
  - (0,0) -> result 0 in cycle 2.
  - (0,9) -> result 9 in cycle 3.
  - (7,0) -> result 7 in cycle 2.
- Worst case and coprime:
  - (15,1) -> result 1 in cycle 18.
  - (13,5) -> result 1.
  - (9,6) -> result 3.
- Backpressure:
  - Stimulus: (6,4) with ostream_rdy=0 for 3 cycles after ostream_val rises, and istream_val held at 1 with different data.
  - Required response:
    - result=2 stable and ostream_val high throughout the stall;
    - istream_rdy=0 throughout the stall;
    - after ostream_rdy=1, IDLE is reached and the new operands are accepted.
- Reset mid-operation:
  - Stimulus: start (15,1), assert rst in cycle 5.
  - Required response:
    - next cycle: state IDLE, ostream_val never asserts, result=0;
    - a following (10,4) yields result 2.
